// File: rtl/cpu_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_boot_ctrl
// Description : Runs one program on the RISC-V core. It streams the program
//               image into the instruction ROM and holds the core in reset.
//               It then releases the core and watches the x26/x27 completion
//               convention. It reports pass, fail or timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ROM_ADDR_W      ROM word-address width (depth = 2**ROM_ADDR_W)
//   RST_HOLD_CYCLES cycles cpu_rst_n stays low before each run (>= 1)
//   SETTLE_CYCLES   cycles between x26==1 and sampling x27 (>= 1)
//   TIMEOUT_CYCLES  maximum RUN cycles before the run is aborted (>= 1)
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   load_valid/ready/data/last program-image stream (valid/ready handshake)
//   restart                   pulse in DONE: rerun the loaded image
//   rom_we/rom_waddr/rom_wdata instruction ROM write port
//   cpu_rst_n                 core reset, active-low
//   x26_val, x27_val          snooped done / pass registers of the core
//   done, pass, timeout       run result (pass/timeout valid while done=1)
//   run_cycles                RUN cycle count of the last or current run
// Build option
//   CPU_BOOT_CYCLE_COUNT_EN   when defined, run_cycles counts RUN cycles;
//                             otherwise run_cycles is tied to zero
// ============================================================================
module cpu_boot_ctrl #(
    parameter int ROM_ADDR_W      = 12,
    parameter int RST_HOLD_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           load_data,
    input  logic                  load_last,
    input  logic                  restart,
    output logic                  rom_we,
    output logic [ROM_ADDR_W-1:0] rom_waddr,
    output logic [31:0]           rom_wdata,
    output logic                  cpu_rst_n,
    input  logic [31:0]           x26_val,
    input  logic [31:0]           x27_val,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [31:0]           run_cycles
);

    localparam logic [2:0] c_ST_LOAD   = 3'd0;
    localparam logic [2:0] c_ST_HOLD   = 3'd1;
    localparam logic [2:0] c_ST_RUN    = 3'd2;
    localparam logic [2:0] c_ST_SETTLE = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic [ROM_ADDR_W-1:0] c_ADDR_LAST   = '1;
    localparam logic [31:0]           c_HOLD_LAST   = 32'(RST_HOLD_CYCLES - 1);
    localparam logic [31:0]           c_SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]           c_TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]           c_CNT_MAX     = '1;

    logic [2:0]            r_state;
    logic [ROM_ADDR_W-1:0] r_addr;
    logic                  r_load_ready;
    logic                  r_rom_we;
    logic [ROM_ADDR_W-1:0] r_rom_waddr;
    logic [31:0]           r_rom_wdata;
    logic                  r_cpu_rst_n;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timeout;
    logic [31:0]           r_step_cnt;   // HOLD and SETTLE share this counter
    logic [31:0]           r_tmo_cnt;

    logic w_accept;
    logic w_image_end;
    logic w_restart;
    logic w_enter_hold;
    logic w_x26_done;

    // load_ready is high only in LOAD, so a handshake implies the LOAD state.
    assign w_accept     = load_valid && r_load_ready;
    assign w_image_end  = w_accept && (load_last || (r_addr == c_ADDR_LAST));
    assign w_restart    = (r_state == c_ST_DONE) && restart;
    assign w_enter_hold = w_image_end || w_restart;
    assign w_x26_done   = (x26_val == 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_LOAD;
            r_addr       <= '0;
            r_load_ready <= 1'b1;
            r_rom_we     <= 1'b0;
            r_rom_waddr  <= '0;
            r_rom_wdata  <= '0;
            r_cpu_rst_n  <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_step_cnt   <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            r_rom_we <= 1'b0;
            case (r_state)
                c_ST_LOAD: begin
                    if (w_accept) begin
                        // The ROM write is registered and lands one cycle after the handshake.
                        r_rom_we    <= 1'b1;
                        r_rom_waddr <= r_addr;
                        r_rom_wdata <= load_data;
                        // The address saturates at the top word and never wraps to 0.
                        if (r_addr != c_ADDR_LAST) begin
                            r_addr <= r_addr + ROM_ADDR_W'(1);
                        end
                    end
                    if (w_image_end) begin
                        r_load_ready <= 1'b0;
                        r_state      <= c_ST_HOLD;
                        r_step_cnt   <= '0;
                        r_tmo_cnt    <= '0;
                    end
                end
                c_ST_HOLD: begin
                    if (r_step_cnt >= c_HOLD_LAST) begin
                        r_state     <= c_ST_RUN;
                        r_cpu_rst_n <= 1'b1;
                    end else begin
                        r_step_cnt <= r_step_cnt + 32'd1;
                    end
                end
                c_ST_RUN: begin
                    if (r_tmo_cnt != c_CNT_MAX) begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
                    // The completion flag takes priority over a timeout in the same cycle.
                    if (w_x26_done) begin
                        r_state    <= c_ST_SETTLE;
                        r_step_cnt <= '0;
                    end else if (r_tmo_cnt >= c_TMO_LAST) begin
                        r_state     <= c_ST_DONE;
                        r_cpu_rst_n <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b1;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_step_cnt >= c_SETTLE_LAST) begin
                        r_state     <= c_ST_DONE;
                        r_cpu_rst_n <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= (x27_val == 32'd1);
                        r_timeout   <= 1'b0;
                    end else begin
                        r_step_cnt <= r_step_cnt + 32'd1;
                    end
                end
                c_ST_DONE: begin
                    // A rerun reuses the ROM contents already loaded.
                    if (w_restart) begin
                        r_state    <= c_ST_HOLD;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_step_cnt <= '0;
                        r_tmo_cnt  <= '0;
                    end
                end
                default: begin
                    r_state     <= c_ST_LOAD;
                    r_cpu_rst_n <= 1'b0;
                end
            endcase
        end
    end

`ifdef CPU_BOOT_CYCLE_COUNT_EN
    logic [31:0] r_run_cycles;

    // The count includes the cycle in which x26 is seen. It is frozen outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cycles <= '0;
        end else if (w_enter_hold) begin
            r_run_cycles <= '0;
        end else if ((r_state == c_ST_RUN) && (r_run_cycles != c_CNT_MAX)) begin
            r_run_cycles <= r_run_cycles + 32'd1;
        end
    end

    assign run_cycles = r_run_cycles;
`else
    assign run_cycles = '0;
`endif

    assign load_ready = r_load_ready;
    assign rom_we     = r_rom_we;
    assign rom_waddr  = r_rom_waddr;
    assign rom_wdata  = r_rom_wdata;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign done       = r_done;
    assign pass       = r_pass;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cpu_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_boot_ctrl
// Description : Self-checking bench for cpu_boot_ctrl. A run-level reference
//               model predicts the accepted image, the reset-hold length, the
//               done cycle, the pass/timeout result and run_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_boot_ctrl;

    localparam int c_AW     = 2;
    localparam int c_DEPTH  = 1 << c_AW;
    localparam int c_HOLD   = 4;
    localparam int c_SETTLE = 10;
    localparam int c_TMO    = 100;

    logic            clk        = 1'b0;
    logic            rst        = 1'b0;
    logic            load_valid = 1'b0;
    logic [31:0]     load_data  = '0;
    logic            load_last  = 1'b0;
    logic            restart    = 1'b0;
    logic [31:0]     x26_val    = '0;
    logic [31:0]     x27_val    = '0;
    logic            load_ready;
    logic            rom_we;
    logic [c_AW-1:0] rom_waddr;
    logic [31:0]     rom_wdata;
    logic            cpu_rst_n;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [31:0]     run_cycles;

    int n_vec   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int end_cyc = 0;

    int          exp_a[$];
    logic [31:0] exp_d[$];
    int          got_a[$];
    logic [31:0] got_d[$];

    cpu_boot_ctrl #(
        .ROM_ADDR_W      (c_AW),
        .RST_HOLD_CYCLES (c_HOLD),
        .SETTLE_CYCLES   (c_SETTLE),
        .TIMEOUT_CYCLES  (c_TMO)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .restart    (restart),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .x26_val    (x26_val),
        .x27_val    (x27_val),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every ROM write seen on the write port.
    always @(negedge clk) begin
        if (rom_we) begin
            got_a.push_back(int'(rom_waddr));
            got_d.push_back(rom_wdata);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream n words. The model accepts words until load_last or the top address.
    task automatic load_image(input int n, input bit use_last, input bit nop);
        int          addr;
        bit          loading;
        logic [31:0] d;
        addr    = 0;
        loading = 1'b1;
        exp_a.delete(); exp_d.delete(); got_a.delete(); got_d.delete();
        for (int i = 0; i < n; i++) begin
            if (loading && ($urandom_range(0, 3) == 0)) begin
                load_valid = 1'b0;
                load_last  = 1'($urandom_range(0, 1));
                check_val("ready_idle", 32'(load_ready), 32'd1);
                tick();
            end
            d          = nop ? 32'h0000_0013 : 32'($urandom);
            load_valid = 1'b1;
            load_data  = d;
            load_last  = use_last && (i == n - 1);
            check_val("ready", 32'(load_ready), 32'(loading));
            if (loading) begin
                exp_a.push_back(addr);
                exp_d.push_back(d);
                if (load_last || (addr == c_DEPTH - 1)) begin
                    loading = 1'b0;
                    end_cyc = cyc + 1;
                end
                addr++;
            end
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check_val("ready_after", 32'(load_ready), 32'd0);
    endtask

    task automatic wait_rise(input string tag);
        int k;
        k = 0;
        while (!cpu_rst_n && (k < 40)) begin
            tick();
            k++;
        end
        check_val(tag, 32'(cyc - end_cyc), 32'(c_HOLD));
    endtask

    task automatic compare_writes();
        check_val("wr_count", 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; (i < got_a.size()) && (i < exp_a.size()); i++) begin
            check_val("wr_addr", 32'(got_a[i]), 32'(exp_a[i]));
            check_val("wr_data", got_d[i], exp_d[i]);
        end
    endtask

    // k: RUN cycle index where x26 becomes 1 (negative = never).
    // rst_at: RUN-relative cycle at which rst is pulsed (negative = none).
    task automatic run_program(input int k, input logic [31:0] x27v, input int rst_at);
        int          exp_j;
        int          got_j;
        int          exp_rc;
        int          low_cnt;
        bit          exp_pass;
        bit          exp_tmo;
        logic [31:0] noise;
        if ((k >= 0) && (k < c_TMO)) begin
            exp_j    = k + 1 + c_SETTLE;
            exp_pass = (x27v == 32'd1);
            exp_tmo  = 1'b0;
            exp_rc   = k + 1;
        end else begin
            exp_j    = c_TMO;
            exp_pass = 1'b0;
            exp_tmo  = 1'b1;
            exp_rc   = c_TMO;
        end
        x27_val = x27v;
        got_j   = -1;
        low_cnt = 0;
        for (int j = 0; j < 400; j++) begin
            if (done) begin
                got_j = j;
                break;
            end
            if (!cpu_rst_n) low_cnt++;
            if (j == rst_at) begin
                rst = 1'b1;
                #1;
                check_val("rst_ready", 32'(load_ready), 32'd1);
                check_val("rst_rstn",  32'(cpu_rst_n),  32'd0);
                check_val("rst_done",  32'(done),       32'd0);
                check_val("rst_we",    32'(rom_we),     32'd0);
                check_val("rst_rc",    run_cycles,      32'd0);
                x26_val = '0;
                restart = 1'b0;
                tick();
                rst = 1'b0;
                return;
            end
            noise = 32'($urandom);
            if (noise == 32'd1) noise = '0;
            x26_val = (j == k) ? 32'd1 : noise;
            restart = ($urandom_range(0, 7) == 0);
            tick();
        end
        x26_val = '0;
        restart = 1'b0;
        check_val("done_cycle",  32'(got_j),     32'(exp_j));
        check_val("rstn_in_run", 32'(low_cnt),   32'd0);
        check_val("pass",        32'(pass),      32'(exp_pass));
        check_val("timeout",     32'(timeout),   32'(exp_tmo));
        check_val("rstn_done",   32'(cpu_rst_n), 32'd0);
`ifdef CPU_BOOT_CYCLE_COUNT_EN
        check_val("run_cycles", run_cycles, 32'(exp_rc));
`else
        check_val("run_cycles", run_cycles, 32'd0 & 32'(exp_rc));
`endif
        repeat (3) tick();
        check_val("done_sticky", 32'(done), 32'd1);
        check_val("pass_held",   32'(pass), 32'(exp_pass));
    endtask

    task automatic do_restart();
        got_a.delete(); got_d.delete();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        end_cyc = cyc;
        check_val("rs_done",    32'(done),       32'd0);
        check_val("rs_pass",    32'(pass),       32'd0);
        check_val("rs_timeout", 32'(timeout),    32'd0);
        check_val("rs_rc",      run_cycles,      32'd0);
        check_val("rs_ready",   32'(load_ready), 32'd0);
        wait_rise("rs_hold");
        check_val("rs_no_write", 32'(got_a.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick_x27();
        case ($urandom_range(0, 2))
            0:       return 32'd1;
            1:       return 32'd0;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        bit ul;
        int ra;
        #1 rst = 1'b1;
        #2;
        check_val("rst_load_ready", 32'(load_ready), 32'd1);
        check_val("rst_rom_we",     32'(rom_we),     32'd0);
        check_val("rst_rom_waddr",  32'(rom_waddr),  32'd0);
        check_val("rst_rom_wdata",  rom_wdata,       32'd0);
        check_val("rst_cpu_rst_n",  32'(cpu_rst_n),  32'd0);
        check_val("rst_done",       32'(done),       32'd0);
        check_val("rst_pass",       32'(pass),       32'd0);
        check_val("rst_timeout",    32'(timeout),    32'd0);
        check_val("rst_run_cycles", run_cycles,      32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Three-word NOP image, then pass, fail, timeout and tie runs.
        load_image(3, 1'b1, 1'b1);
        wait_rise("hold");
        compare_writes();
        run_program(50, 32'd1, -1);
        do_restart();
        run_program(50, 32'd0, -1);
        do_restart();
        run_program(-1, 32'd1, -1);
        do_restart();
        run_program(c_TMO - 1, 32'd1, -1);
        do_restart();
        run_program(20, 32'd1, 7);

        // ROM-full image: six words without load_last, only four are accepted.
        load_image(6, 1'b0, 1'b0);
        wait_rise("hold_full");
        compare_writes();
        run_program(30, 32'd1, -1);
        do_restart();
        run_program(10, 32'd1, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        for (int it = 0; it < 12; it++) begin
            n  = $urandom_range(1, 6);
            ul = (n < c_DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            load_image(n, ul, 1'b0);
            wait_rise("hold_rand");
            compare_writes();
            run_program($urandom_range(0, 120), pick_x27(), -1);
            do_restart();
            ra = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : -1;
            run_program($urandom_range(0, 120), pick_x27(), ra);
            if (ra < 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
- Sequences one program run of the RISC-V core: streams a program image into the instruction ROM, holds the core in reset, releases it, and watches the x26/x27 completion convention.
- Reports pass, fail or timeout when the run ends.
- Sits between the program-load source (bench or UART loader) and risc_v_cpu. It owns the ROM write port and the core reset.

Parameters:
- ROM_ADDR_W, 12: ROM word-address width; depth = 2^ROM_ADDR_W words.
- RST_HOLD_CYCLES, 4: cycles cpu_rst_n is held low before each run; legal range is 1 or more.
- SETTLE_CYCLES, 10: cycles to wait after x26==1 before sampling x27. Ten cycles equals 200 ns at a 20 ns clock.
- TIMEOUT_CYCLES, 100000: maximum RUN cycles before the run is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  program word valid
- load_ready  out  1  controller accepts a word
- load_data  in  32  program word
- load_last  in  1  marks the final word of the image
- restart  in  1  pulse; rerun the loaded program from DONE
- rom_we  out  1  ROM write enable
- rom_waddr  out  ROM_ADDR_W  ROM word address
- rom_wdata  out  32  ROM write data
- cpu_rst_n  out  1  core reset, active-low
- x26_val  in  32  snooped value of register x26 (done flag)
- x27_val  in  32  snooped value of register x27 (pass flag)
- done  out  1  run finished (sticky until restart or rst)
- pass  out  1  run passed (valid while done=1)
- timeout  out  1  run aborted by timeout (valid while done=1)
- run_cycles  out  32  cycle count of the last or current run

Behaviour:
- Reset values:
  - State is LOAD; load_ready=1; rom_we=0; rom_waddr=0; rom_wdata=0.
  - cpu_rst_n=0.
  - done=0; pass=0; timeout=0; run_cycles=0.
- States: LOAD, HOLD, RUN, SETTLE, DONE.
- LOAD:
  - load_ready=1; cpu_rst_n=0.
  - A word is accepted when load_valid && load_ready.
  - On acceptance, the next cycle drives rom_we=1 with rom_waddr = the address counter and rom_wdata = load_data. The counter then increments. The write appears one cycle after the handshake.
  - The image ends when load_last is accepted, or when a word is accepted at address 2^ROM_ADDR_W-1 (ROM full).
  - On image end, load_ready drops the next cycle, the state moves to HOLD, and no further words are accepted.
  - The address counter does not wrap into address 0.
- HOLD:
  - cpu_rst_n=0 for exactly RST_HOLD_CYCLES cycles, then the state moves to RUN.
  - The final rom_we write completes before cpu_rst_n rises.
- RUN:
  - cpu_rst_n=1; the cycle counter increments each cycle.
  - x26_val==32'd1 moves the state to SETTLE.
  - If the counter reaches TIMEOUT_CYCLES first, the state moves to DONE with timeout=1 and pass=0.
  - If x26 and timeout occur in the same cycle, x26 wins.
- SETTLE:
  - cpu_rst_n stays 1; count SETTLE_CYCLES.
  - On the last count, sample x27_val: pass = (x27_val==32'd1).
  - Then move to DONE with timeout=0.
- DONE:
  - done=1; cpu_rst_n=0 (core frozen); outputs are held.
  - restart=1 clears done, pass and timeout and moves to HOLD. The ROM is not reloaded.
  - restart is ignored in every other state.
- rst asserted mid-operation:
  - Immediate return to LOAD with cpu_rst_n=0; the address counter clears.
  - The ROM contents are not touched.
- All counters are unsigned and saturate; none wraps.

Optional Feature:
- Macro: CPU_BOOT_CYCLE_COUNT_EN.
- When defined:
  - run_cycles counts cycles spent in RUN, including the cycle x26 is seen.
  - It is frozen in SETTLE and DONE and cleared on entry to HOLD.
- When undefined:
  - run_cycles is tied to 0 and the counter logic is absent.
  - The timeout counter is retained internally.

Test Plan:
- Load 3 words 0x00000013, 0x00000013, 0x00000013 with load_last on the third:
  - rom_we pulses at addresses 0, 1, 2 with matching data.
  - load_ready falls after the third word.
  - cpu_rst_n rises exactly RST_HOLD_CYCLES=4 cycles after HOLD entry.
- In RUN, drive x26_val=1 at cycle 50 and hold x27_val=1:
  - done=1 and pass=1 after SETTLE_CYCLES=10.
  - run_cycles=51 with the macro defined.
- Same as above but x27_val=0: done=1, pass=0, timeout=0.
- TIMEOUT_CYCLES=100 with x26_val held 0: done=1, timeout=1, pass=0 at RUN cycle 100; cpu_rst_n=0.
- ROM_ADDR_W=2, stream 6 words without load_last:
  - Only addresses 0 to 3 are written.
  - load_ready=0 after the 4th word; words 5 and 6 are not accepted.
- rst mid-RUN: state returns to LOAD, cpu_rst_n=0, load_ready=1. Then restart from DONE reruns without reload: no rom_we pulse, and done clears.
